// File: rtl/seq_det_pkg.sv
// Shared types and reset constants for the sequence-detector controller.
//   state_e            : controller FSM state (IDLE, SHIFT)
//   SEQDET_RST_PAT     : pattern loaded at reset (zero-extended to PAT_W)
//   SEQDET_RST_THRESH  : match threshold loaded at reset
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [3:0]  SEQDET_RST_PAT    = 4'b1010;
  localparam int unsigned SEQDET_RST_THRESH = 1;

endpackage

// File: rtl/seq_det_if.sv
// Word-stream valid/ready handshake feeding the controller.
//   in_valid : producer has a word
//   in_ready : controller accepts a word this cycle
//   in_data  : DATA_W-bit word, serialized MSB-first
interface seq_det_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/seq_det_ctrl_pattern_det.sv
// Bit-serial Moore pattern detector with a PAT_W-bit history and fill count.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clears history, fill and match
//   en       : shift bit_in into history this cycle
//   bit_in   : serial data bit
//   pattern  : pattern to detect, first-received bit is MSB
//   match    : registered one-cycle detect pulse
// Build option: SEQDET_OVERLAP_EN keeps fill after a match (overlapping
// detection); otherwise fill restarts so the next match needs PAT_W new bits.
module pattern_det #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_sh;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;

  // Next history/fill and compare against the updated history.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    hist_sh = {hist_q[PAT_W-2:0], bit_in};
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_sh;
      if (fill_q != FILL_W'(PAT_W)) fill_d = fill_q + FILL_W'(1);
      match_d = (hist_sh == pattern) && (fill_d == FILL_W'(PAT_W));
`ifdef SEQDET_OVERLAP_EN
      // Fill stays saturated: bits of this match may start the next one.
`else
      if (match_d) fill_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Serializes handshaked words MSB-first into pattern_det, counts detections
// and raises a sticky interrupt at a programmable match count.
//   clk, rst   : clock, synchronous active-high reset
//   in_if      : word stream (slave side of seq_det_if)
//   cfg_we     : load cfg_pat/cfg_thresh, honored only while not busy
//   cfg_pat    : detection pattern
//   cfg_thresh : match count that sets irq (0 disables irq)
//   busy       : a word is being serialized
//   match      : registered detect pulse
//   match_cnt  : saturating detection count since reset/config
//   irq        : sticky threshold interrupt
//   irq_clr    : clears irq (a simultaneous set wins)
// Build option: SEQDET_OVERLAP_EN selects overlapping detection in pattern_det.
module seq_det_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_det_if.slave         in_if,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq,
  input  logic             irq_clr
);

  import seq_det_pkg::*;

  localparam int unsigned     IDX_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0]  thr_q, thr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              irq_q, irq_d;
  logic              accept_c, cfg_ok_c, det_en_c, det_bit_c, det_match, inc_c;

  // FSM next state, serializer, config, counter and irq.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    idx_d     = idx_q;
    pat_d     = pat_q;
    thr_d     = thr_q;
    cnt_d     = cnt_q;
    irq_d     = irq_q;
    accept_c  = in_if.in_valid & rdy_q;
    cfg_ok_c  = cfg_we & ~busy_q;
    det_en_c  = (state_q == SHIFT);
    det_bit_c = sr_q[DATA_W-1];
    inc_c     = det_match && (cnt_q != CNT_MAX);

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          sr_d    = in_if.in_data;
          idx_d   = IDX_W'(DATA_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {sr_q[DATA_W-2:0], 1'b0};
        idx_d = idx_q - IDX_W'(1);
        if (idx_q == '0) begin
          // Last bit: reload without a bubble if a word is waiting.
          if (accept_c) begin
            sr_d  = in_if.in_data;
            idx_d = IDX_W'(DATA_W - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready is registered, so derive it from the next state.
    rdy_d  = (state_d == IDLE) || (idx_d == '0);
    busy_d = (state_d == SHIFT);

    if (cfg_ok_c) begin
      pat_d = cfg_pat;
      thr_d = cfg_thresh;
      cnt_d = '0;
      irq_d = 1'b0;
    end else begin
      if (irq_clr) irq_d = 1'b0;
      if (inc_c) begin
        cnt_d = cnt_q + CNT_W'(1);
        if ((thr_q != '0) && (cnt_d == thr_q)) irq_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      pat_q   <= PAT_W'(SEQDET_RST_PAT);
      thr_q   <= CNT_W'(SEQDET_RST_THRESH);
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      pat_q   <= pat_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  pattern_det #(.PAT_W(PAT_W)) u_det (
    .clk     (clk),
    .rst     (rst),
    .clr     (cfg_ok_c),
    .en      (det_en_c),
    .bit_in  (det_bit_c),
    .pattern (pat_q),
    .match   (det_match)
  );

  assign in_if.in_ready = rdy_q;
  assign busy           = busy_q;
  assign match          = det_match;
  assign match_cnt      = cnt_q;
  assign irq            = irq_q;

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Controller that feeds a programmable-pattern Moore sequence detector from a parallel word stream. It accepts DATA_W-bit words over a valid/ready handshake and serializes them MSB-first into the detector at one bit per clock. It counts detections and raises a sticky interrupt when a configured match threshold is reached. It sits between a byte-oriented producer and the bit-serial detection logic, replacing hand-driven per-bit stimulus of a fixed 1010 detector.

## Interface
- DATA_W, 8, input word width (≥2)
- PAT_W, 4, pattern length in bits (2..8)
- CNT_W, 8, match counter width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  load cfg_pat/cfg_thresh; honored only when busy=0
- cfg_pat  in  PAT_W  pattern; first-received bit is MSB
- cfg_thresh  in  CNT_W  match count that raises irq; 0 disables irq
- in_valid  in  1  word available
- in_ready  out  1  controller can accept a word this cycle
- in_data  in  DATA_W  word, shifted out MSB-first
- busy  out  1  serialization in progress
- match  out  1  registered Moore detect pulse
- match_cnt  out  CNT_W  detections since last cfg_we/reset, saturating
- irq  out  1  sticky threshold interrupt
- irq_clr  in  1  clears irq

## Operation
- FSM states: IDLE and SHIFT. busy=1 in SHIFT.
- IDLE: in_ready=1. An accept (in_valid&in_ready) loads the shift register, sets bit index to DATA_W-1, and moves to SHIFT.
- SHIFT: each cycle drives sr[MSB] to the detector with det_en=1, shifts left, and decrements the index. in_ready=1 only on the last bit (index 0).
  - Accept on the last bit: reload and stay in SHIFT (back-to-back, no bubble).
  - No accept on the last bit: go to IDLE.
- Detector holds a PAT_W-bit history and a fill count (0..PAT_W). On det_en, the bit shifts in and fill increments, saturating at PAT_W. match is registered: it goes to 1 when the updated history equals the pattern and fill reaches PAT_W.
- History persists across words and idle gaps, so matches may span word boundaries.
- match_cnt increments, saturating at all-ones, in each cycle that match=1.
- irq is set when an increment makes match_cnt equal cfg_thresh (thresh≠0). It then holds until irq_clr. If set and irq_clr occur in the same cycle, set wins.
- cfg_we while busy=1 is ignored. When accepted, cfg_we loads pattern and threshold and clears match_cnt, irq, history/fill and match.
- Reset values: state IDLE, in_ready=1, busy=0, match=0, match_cnt=0, irq=0, pattern=1010 (low 4 bits, zero-extended upward), thresh=1, fill=0.

## Timing
- Word accepted at edge E: its MSB reaches the detector in cycle E+1, and its last bit in cycle E+DATA_W.
- Bit consumed in cycle t: match=1 in cycle t+1, lasting one cycle per detection. match_cnt shows the increment in cycle t+2. irq is visible in cycle t+2.
- Sustained throughput is one word per DATA_W cycles.
- rst mid-word: the partial word is discarded, and all reset values appear the cycle after rst is sampled.

## Configuration
- SEQDET_OVERLAP_EN defined: overlapping detection; history and fill are kept after a match.
- SEQDET_OVERLAP_EN undefined: non-overlapping detection; fill clears to 0 on the matching edge, so the next match needs PAT_W fresh bits.

## Structure
- Package seq_det_pkg holds:
  - the FSM state enum (IDLE, SHIFT),
  - the reset pattern constant SEQDET_RST_PAT=4'b1010,
  - the reset threshold constant.
- Sub-module pattern_det (clk, rst, clr, en, bit_in, pattern, match) holds history, fill and the registered compare. The controller owns the FSM, the shift register, the counter and irq.

## Test plan
- Reset: after rst, in_ready=1, busy=0, match=0, match_cnt=0, irq=0; default pattern 1010 is active.
- Default pattern, send 0xAA: overlap build gives match pulses after bits 4, 6 and 8, with match_cnt=3 and irq set at count 1. Non-overlap build gives match_cnt=2.
- Boundary span: send 0x01 then 0x40 back-to-back. in_ready stays high on the last bit, there is no idle gap, exactly 1 match across the boundary, match_cnt=1.
- Threshold: cfg_pat=1111, cfg_thresh=2, send 0xFF. Overlap build gives 5 matches, with irq rising on the 2nd. irq_clr afterwards leaves irq=0 while match_cnt=5. Non-overlap build gives 2 matches and irq on the 2nd.
- Config/reset guards: cfg_we during SHIFT is ignored, and the pattern is unchanged. rst asserted at bit 3 of a word gives in_ready=1 and match_cnt=0 next cycle, with pattern 1010 restored.
- Saturation: with CNT_W=2, the 0xAA overlap stream repeated gives match_cnt holding 3 with no wrap.
